// File: rtl/sr_bank_driver.sv
// Command-side driver for a bank of SR flip-flops.
// Takes register-update commands over valid/ready, excites S/R from a shadow
// copy of the bank, reads the bank back and re-drives on mismatch.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | ready for a command; target latched on accept
// DRIVE  | one cycle of S/R excitation toward the target
// SETTLE | excitation released, waiting for the bank outputs to settle
// CHECK  | compare readback against target; retry, or finish
// RESP   | one-cycle response pulse, then back to IDLE
module sr_bank_driver #(
   parameter int WIDTH     = 8,
   parameter int SETTLE    = 1,
   parameter int MAX_RETRY = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic [1:0]       req_op_i,
   input  logic [WIDTH-1:0] req_data_i,
   output logic [WIDTH-1:0] s_out_o,
   output logic [WIDTH-1:0] r_out_o,
   input  logic [WIDTH-1:0] q_in_i,
   output logic             rsp_valid_o,
   output logic             rsp_err_o,
   output logic [WIDTH-1:0] rsp_q_o
);

   localparam int CNT_W = 4;
   localparam int RTY_W = 3;
   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE - 1);
   localparam logic [RTY_W-1:0] RETRY_LAST  = RTY_W'(MAX_RETRY);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_DRIVE  = 3'd1;
   localparam logic [2:0] ST_SETTLE = 3'd2;
   localparam logic [2:0] ST_CHECK  = 3'd3;
   localparam logic [2:0] ST_RESP   = 3'd4;

   localparam logic [1:0] OP_LOAD   = 2'b00;
   localparam logic [1:0] OP_SET    = 2'b01;
   localparam logic [1:0] OP_CLEAR  = 2'b10;

   logic [2:0]       state_q,     state_d;
   logic [WIDTH-1:0] shadow_q,    shadow_d;
   logic [WIDTH-1:0] target_q,    target_d;
   logic [RTY_W-1:0] retry_q,     retry_d;
   logic [CNT_W-1:0] cnt_q,       cnt_d;
   logic [WIDTH-1:0] s_q,         s_d;
   logic [WIDTH-1:0] r_q,         r_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic             rsp_err_q,   rsp_err_d;
   logic [WIDTH-1:0] rsp_q_q,     rsp_q_d;
   logic [WIDTH-1:0] tgt_new;

   // New target from the current shadow and the offered command.
   always_comb begin
      tgt_new = req_data_i;
      case (req_op_i)
         OP_LOAD:  tgt_new = req_data_i;
         OP_SET:   tgt_new = shadow_q | req_data_i;
         OP_CLEAR: tgt_new = shadow_q & ~req_data_i;
         default:  tgt_new = shadow_q ^ req_data_i;
      endcase
   end

   // Sequencer next-state; excitation is only ever nonzero for the DRIVE cycle.
   always_comb begin
      state_d     = state_q;
      shadow_d    = shadow_q;
      target_d    = target_q;
      retry_d     = retry_q;
      cnt_d       = cnt_q;
      s_d         = '0;
      r_d         = '0;
      rsp_valid_d = 1'b0;
      rsp_err_d   = rsp_err_q;
      rsp_q_d     = rsp_q_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid_i) begin
               target_d = tgt_new;
               retry_d  = '0;
               s_d      = tgt_new & ~shadow_q;
               r_d      = ~tgt_new & shadow_q;
               state_d  = ST_DRIVE;
            end
         end
         ST_DRIVE: begin
            cnt_d   = SETTLE_LOAD;
            state_d = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (cnt_q == '0) begin
               state_d = ST_CHECK;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_CHECK: begin
            // Shadow always follows the readback, so a retry re-drives only
            // the bits that actually disagree with the target.
            shadow_d = q_in_i;
            if (q_in_i == target_q) begin
               rsp_err_d   = 1'b0;
               rsp_q_d     = q_in_i;
               rsp_valid_d = 1'b1;
               state_d     = ST_RESP;
            end else if (retry_q < RETRY_LAST) begin
               retry_d = retry_q + RTY_W'(1);
               s_d     = target_q & ~q_in_i;
               r_d     = ~target_q & q_in_i;
               state_d = ST_DRIVE;
            end else begin
               rsp_err_d   = 1'b1;
               rsp_q_d     = q_in_i;
               rsp_valid_d = 1'b1;
               state_d     = ST_RESP;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers, synchronous reset drops any in-flight command.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         shadow_q    <= '0;
         target_q    <= '0;
         retry_q     <= '0;
         cnt_q       <= '0;
         s_q         <= '0;
         r_q         <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_q_q     <= '0;
      end else begin
         state_q     <= state_d;
         shadow_q    <= shadow_d;
         target_q    <= target_d;
         retry_q     <= retry_d;
         cnt_q       <= cnt_d;
         s_q         <= s_d;
         r_q         <= r_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_q_q     <= rsp_q_d;
      end
   end

   assign req_ready_o = (state_q == ST_IDLE);
   assign s_out_o     = s_q;
   assign r_out_o     = r_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_err_o   = rsp_err_q;
   assign rsp_q_o     = rsp_q_q;

endmodule

// File: tb/tb_sr_bank_driver.sv
// Bench for sr_bank_driver: SR bank model with fault injection, a
// transaction-timeline reference model compared every cycle, and directed
// commands with hand-computed expectations.
module tb_sr_bank_driver;

   localparam int W  = 8;
   localparam int ST = 1;
   localparam int MR = 2;
   localparam int P  = ST + 2;   // cycles per drive attempt

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         req_valid, req_ready, rsp_valid, rsp_err;
   logic [1:0]   req_op;
   logic [W-1:0] req_data, s_out, r_out, q_in, rsp_q;

   int ntests = 0;
   int nfail  = 0;
   int rv_count = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   sr_bank_driver #(.WIDTH(W), .SETTLE(ST), .MAX_RETRY(MR)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_op_i    (req_op),
      .req_data_i  (req_data),
      .s_out_o     (s_out),
      .r_out_o     (r_out),
      .q_in_i      (q_in),
      .rsp_valid_o (rsp_valid),
      .rsp_err_o   (rsp_err),
      .rsp_q_o     (rsp_q)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // SR bank: stuck-at-0 outputs and a one-shot lost set on bit3
   logic [W-1:0] bank_q;
   logic [W-1:0] stuck_mask;
   logic         tr_req;
   logic         tr_used = 1'b0;
   assign q_in = bank_q & ~stuck_mask;

   always @(posedge clk) begin : bank_blk
      logic [W-1:0] s_eff;
      s_eff = s_out;
      if (tr_req && !tr_used && s_out[3]) begin
         s_eff[3] = 1'b0;
         tr_used <= 1'b1;
      end
      if (rst) bank_q <= '0;
      else     bank_q <= (bank_q | s_eff) & ~r_out;
   end

   // Reference model: each command is a series of attempts of P cycles
   // (drive, settle, check) followed by a single response cycle.
   logic         m_busy;
   int           m_ph, m_att;
   logic [W-1:0] m_tgt, m_sh, m_q;
   logic         m_err;

   always @(posedge clk) begin
      if (rst) begin
         m_busy = 1'b0; m_ph = 0; m_att = 0;
         m_tgt = '0; m_sh = '0; m_q = '0; m_err = 1'b0;
      end else if (!m_busy) begin
         if (req_valid) begin
            case (req_op)
               2'b00:   m_tgt = req_data;
               2'b01:   m_tgt = m_sh | req_data;
               2'b10:   m_tgt = m_sh & ~req_data;
               default: m_tgt = m_sh ^ req_data;
            endcase
            m_busy = 1'b1; m_ph = 0; m_att = 0;
         end
      end else if (m_ph == P - 1) begin
         m_sh = q_in;
         if (q_in == m_tgt || m_att == MR) begin
            m_err = (q_in != m_tgt);
            m_q   = q_in;
            m_ph  = P;
         end else begin
            m_att++;
            m_ph = 0;
         end
      end else if (m_ph == P) begin
         m_busy = 1'b0;
      end else begin
         m_ph++;
      end
   end

   // Per-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (chk_en) begin
         logic [W-1:0] es, er;
         es = (m_busy && m_ph == 0) ? (m_tgt & ~m_sh) : '0;
         er = (m_busy && m_ph == 0) ? (~m_tgt & m_sh) : '0;
         check("ready",     req_ready, !m_busy);
         check("s_out",     s_out, es);
         check("r_out",     r_out, er);
         check("rsp_valid", rsp_valid, (m_busy && m_ph == P));
         check("rsp_err",   rsp_err, m_err);
         check("rsp_q",     rsp_q, m_q);
         ntests++;
         assert ((s_out & r_out) == '0) else begin
            nfail++;
            $display("FAIL s_and_r: overlap 0x%0h expected 0x0", s_out & r_out);
         end
         if (rsp_valid) rv_count++;
      end
   end

   // One command from IDLE; returns at the negedge after the response cycle.
   task automatic run_cmd(input logic [1:0] op, input logic [W-1:0] d,
                          output int lat, output logic err, output logic [W-1:0] q,
                          output logic [W-1:0] s1, output logic [W-1:0] r1,
                          output int nz, output logic [W-1:0] last_s);
      int c;
      bit done;
      req_op = op; req_data = d; req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0; req_data = ~d; req_op = op + 2'd1;
      c = 1; nz = 0; lat = -1; err = 1'b0; q = '0; done = 1'b0;
      s1 = s_out; r1 = r_out; last_s = '0;
      while (!done && c < 60) begin
         if ((s_out | r_out) != '0) begin
            nz++;
            last_s = s_out;
         end
         if (rsp_valid) begin
            lat = c; err = rsp_err; q = rsp_q; done = 1'b1;
         end else begin
            @(negedge clk);
            c++;
         end
      end
      check("rsp_timeout", done, 1);
      @(negedge clk);
   endtask

   int           lat, nz, rv0;
   logic         err;
   logic [W-1:0] q, s1, r1, ls;
   logic [W-1:0] b_op_s[4], b_op_r[4], b_q[4];
   logic         b_err[4];
   logic [1:0]   b2b_op[4];
   logic [W-1:0] b2b_d[4];

   initial begin
      req_valid = 1'b0; req_op = 2'b00; req_data = '0;
      stuck_mask = '0; tr_req = 1'b0;
      b2b_op[0] = 2'b00; b2b_d[0] = 8'h3C;
      b2b_op[1] = 2'b01; b2b_d[1] = 8'h40;
      b2b_op[2] = 2'b10; b2b_d[2] = 8'h0C;
      b2b_op[3] = 2'b00; b2b_d[3] = 8'h70;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_en = 1'b1;
      check("rst_ready", req_ready, 1);
      check("rst_s", s_out, 0);
      check("rst_r", r_out, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_q", rsp_q, 0);
      rst = 1'b0;
      @(negedge clk);

      run_cmd(2'b00, 8'hA5, lat, err, q, s1, r1, nz, ls);
      check("load_s", s1, 8'hA5);
      check("load_r", r1, 8'h00);
      check("load_lat", lat, 4);
      check("load_err", err, 0);
      check("load_q", q, 8'hA5);

      run_cmd(2'b01, 8'h0F, lat, err, q, s1, r1, nz, ls);
      check("set_s", s1, 8'h0A);
      check("set_r", r1, 8'h00);
      check("set_q", q, 8'hAF);

      run_cmd(2'b10, 8'hF0, lat, err, q, s1, r1, nz, ls);
      check("clr_s", s1, 8'h00);
      check("clr_r", r1, 8'hA0);
      check("clr_q", q, 8'h0F);

      run_cmd(2'b11, 8'hFF, lat, err, q, s1, r1, nz, ls);
      check("tgl_s", s1, 8'hF0);
      check("tgl_r", r1, 8'h0F);
      check("tgl_q", q, 8'hF0);

      stuck_mask = 8'h01;
      run_cmd(2'b00, 8'h01, lat, err, q, s1, r1, nz, ls);
      check("stuck_s1", s1, 8'h01);
      check("stuck_drives", nz, 3);
      check("stuck_last_s", ls, 8'h01);
      check("stuck_lat", lat, 10);
      check("stuck_err", err, 1);
      check("stuck_q", q, 8'h00);

      run_cmd(2'b00, 8'h00, lat, err, q, s1, r1, nz, ls);
      check("zero_s", s1, 8'h00);
      check("zero_r", r1, 8'h00);
      check("zero_drives", nz, 0);
      check("zero_err", err, 0);
      stuck_mask = '0;

      tr_req = 1'b1;
      run_cmd(2'b00, 8'h08, lat, err, q, s1, r1, nz, ls);
      check("trans_drives", nz, 2);
      check("trans_s2", ls, 8'h08);
      check("trans_lat", lat, 7);
      check("trans_err", err, 0);
      check("trans_q", q, 8'h08);

      // reset during SETTLE of LOAD 0xFF
      req_op = 2'b00; req_data = 8'hFF; req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      check("rstmid_drive_s", s_out, 8'hF7);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rstmid_ready", req_ready, 1);
      check("rstmid_s", s_out, 0);
      check("rstmid_rsp_valid", rsp_valid, 0);
      check("rstmid_rsp_q", rsp_q, 0);
      rst = 1'b0;
      rv0 = rv_count;
      repeat (4) @(negedge clk);
      check("rstmid_no_rsp", rv_count - rv0, 0);
      run_cmd(2'b01, 8'h01, lat, err, q, s1, r1, nz, ls);
      check("post_rst_s", s1, 8'h01);
      check("post_rst_r", r1, 8'h00);
      check("post_rst_q", q, 8'h01);

      // back-to-back with req_valid held high
      rv0 = rv_count;
      req_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         int c;
         c = 0;
         while (!req_ready && c < 20) begin
            @(negedge clk);
            c++;
         end
         check("b2b_ready_timeout", req_ready, 1);
         req_op = b2b_op[k]; req_data = b2b_d[k];
         @(posedge clk);
         @(negedge clk);
         check("b2b_ready_low", req_ready, 0);
         b_op_s[k] = s_out; b_op_r[k] = r_out;
         req_op = 2'b11; req_data = 8'hFF;
         c = 0;
         while (!rsp_valid && c < 40) begin
            @(negedge clk);
            c++;
         end
         check("b2b_rsp_timeout", rsp_valid, 1);
         b_q[k] = rsp_q; b_err[k] = rsp_err;
         @(negedge clk);
      end
      req_valid = 1'b0;
      check("b2b_s0", b_op_s[0], 8'h3C);
      check("b2b_r0", b_op_r[0], 8'h01);
      check("b2b_s1", b_op_s[1], 8'h40);
      check("b2b_r2", b_op_r[2], 8'h0C);
      check("b2b_noop_s", b_op_s[3], 8'h00);
      check("b2b_noop_r", b_op_r[3], 8'h00);
      check("b2b_q0", b_q[0], 8'h3C);
      check("b2b_q1", b_q[1], 8'h7C);
      check("b2b_q2", b_q[2], 8'h70);
      check("b2b_q3", b_q[3], 8'h70);
      check("b2b_noop_err", b_err[3], 0);
      repeat (3) @(negedge clk);
      check("b2b_pulses", rv_count - rv0, 4);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule

// File: doc/sr_bank_driver.md
Name: sr_bank_driver

Overview:
- Command-side driver for a bank of WIDTH SR flip-flops that reset on the same clk/rst.
- Accepts register-update commands over a valid/ready handshake.
- Per bit, derives S/R excitation from a shadow copy of the bank state. It never drives S=R=1.
- After the update it reads back the bank outputs, retries on mismatch, and returns one response per command.

Parameters:
- WIDTH, 8, number of SR flip-flops driven.
- SETTLE, 1, cycles between excitation and readback compare; legal range 1..15.
- MAX_RETRY, 2, re-drive attempts after the first mismatch before error; legal range 0..7.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  command valid
- req_ready  output  1  driver can accept a command; high only in IDLE
- req_op  input  2  00 LOAD, 01 SET-mask, 10 CLEAR-mask, 11 TOGGLE-mask
- req_data  input  WIDTH  load value or bit mask
- s_out  output  WIDTH  set excitation to the bank
- r_out  output  WIDTH  reset excitation to the bank
- q_in  input  WIDTH  bank Q readback
- rsp_valid  output  1  one-cycle response pulse; no backpressure
- rsp_err  output  1  valid with rsp_valid; 1 means readback never matched
- rsp_q  output  WIDTH  valid with rsp_valid; q_in sampled in the final CHECK

Behaviour:
- Reset: state IDLE, shadow=0, target=0, retry=0, settle counter=0. s_out=0, r_out=0, rsp_valid=0, rsp_err=0, rsp_q=0, req_ready=1.
- Reset applies in any state, including mid-command. The in-flight command is dropped and no response is issued.
- All outputs are registered except req_ready, which is decoded from the state.
- Target is computed at accept from the current shadow:
  - LOAD: data
  - SET: shadow | data
  - CLEAR: shadow & ~data
  - TOGGLE: shadow ^ data
- Excitation, computed entering DRIVE:
  - s = target & ~shadow
  - r = ~target & shadow
  - s & r == 0 always; this is a design invariant and is asserted in the bench.
- FSM states: IDLE, DRIVE, SETTLE, CHECK, RESP.
- IDLE: req_ready=1. When req_valid & req_ready at an edge, capture target, retry=0, go to DRIVE. With req_valid low, stay in IDLE.
- DRIVE: exactly one cycle. s_out/r_out hold the excitation; outputs are zero in every other state. Go to SETTLE with counter=SETTLE-1.
- SETTLE: s_out=r_out=0. Decrement the counter; go to CHECK when the counter is 0.
- CHECK: one cycle; sample q_in at the closing edge.
  - q_in==target: shadow<=target, rsp_err<=0, go to RESP.
  - Mismatch with retry<MAX_RETRY: shadow<=q_in (resync), retry++, go to DRIVE. Excitation is recomputed from the resynced shadow against the unchanged target.
  - Mismatch with retry==MAX_RETRY: shadow<=q_in, rsp_err<=1, go to RESP.
  - In both RESP paths, rsp_q<=q_in.
- RESP: rsp_valid=1 for exactly one cycle, then go to IDLE. rsp_err and rsp_q hold their values until the next response.
- Latency, accept edge at cycle 0, no retry: DRIVE is cycle 1, CHECK is cycle 1+SETTLE+1, rsp_valid is cycle SETTLE+3. Next accept is possible at the edge ending cycle SETTLE+4.
- Each retry adds SETTLE+2 cycles.
- No-op command (target==shadow): still runs DRIVE with all-zero excitation, then the full sequence. One response per command without exception.
- req_data and req_op are ignored outside the accept edge. Changing them mid-command has no effect.
- WIDTH arithmetic is bitwise only; there is no carry or wrap.

Test Plan:
- Reset then LOAD 0xA5, q_in modelled by a WIDTH-bit SR bank -> DRIVE cycle s_out=0xA5, r_out=0x00; rsp_valid at cycle 4 (SETTLE=1), rsp_err=0, rsp_q=0xA5.
- From shadow 0xA5: SET 0x0F -> s_out=0x0A, r_out=0x00, rsp_q=0xAF. CLEAR 0xF0 -> r_out=0xA0, rsp_q=0x0F. TOGGLE 0xFF -> s_out=0xF0, r_out=0x0F, rsp_q=0xF0. Check s_out&r_out==0 every cycle.
- Bank model forces bit0 stuck at 0, LOAD 0x01, MAX_RETRY=2 -> three DRIVE pulses, each s_out=0x01; rsp_err=1, rsp_q=0x00; the next LOAD 0x00 produces an all-zero excitation.
- Transient fault (bit3 fails the first write only), LOAD 0x08 -> second DRIVE s_out=0x08, rsp_err=0, total latency 7 cycles with SETTLE=1.
- rst asserted during SETTLE of LOAD 0xFF -> next cycle is IDLE, all outputs 0, no rsp_valid; a following SET 0x01 yields s_out=0x01 (shadow is 0).
- Back-to-back req_valid held high with 4 commands -> req_ready low from cycle 1 to RESP, exactly 4 rsp_valid pulses in order; a no-op LOAD of the current value gives zero excitation and rsp_err=0.
